// File: rtl/roce_ack_responder_pkg.sv
// RoCE v2 constants, PSN classification and ACK header bundle shared by the
// RC responder logic.
package RoCE_params;

    localparam logic [7:0] RC_RDMA_WRITE_FIRST    = 8'h06;
    localparam logic [7:0] RC_RDMA_WRITE_MIDDLE   = 8'h07;
    localparam logic [7:0] RC_RDMA_WRITE_LAST     = 8'h08;
    localparam logic [7:0] RC_RDMA_WRITE_LAST_IMD = 8'h09;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY     = 8'h0A;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY_IMD = 8'h0B;
    localparam logic [7:0] RC_RDMA_ACK            = 8'h11;

    localparam logic [7:0] AETH_ACK         = 8'h1F;
    localparam logic [7:0] AETH_NAK_PSN_SEQ = 8'h60;
    localparam logic [7:0] AETH_NAK_INV_REQ = 8'h61;

    typedef enum logic [1:0] {
        IN_SEQ = 2'd0,
        DUP    = 2'd1,
        AHEAD  = 2'd2
    } psn_class_t;

    typedef struct packed {
        logic [23:0] psn;
        logic [7:0]  syndrome;
        logic [23:0] msn;
    } ack_hdr_t;

    // Upper half of the mod-2^24 window counts as already received.
    function automatic psn_class_t psn_classify(
        input logic [23:0] psn,
        input logic [23:0] epsn
    );
        logic [23:0] d;
        d = psn - epsn;
        if (d == 24'd0)
            return IN_SEQ;
        else if (d[23])
            return DUP;
        else
            return AHEAD;
    endfunction

endpackage

// File: rtl/roce_ack_responder.sv
// RC responder ACK/NAK generator for RDMA WRITE traffic on one QP.
// Define ROCE_ACK_COALESCE_EN to ACK only on AckReq/LAST/ONLY and coalesce.
module roce_ack_responder
    import RoCE_params::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_load,
    input  logic [23:0] cfg_start_psn,
    input  logic [23:0] cfg_loc_qp,
    input  logic [23:0] cfg_rem_qp,
    input  logic        s_roce_rx_bth_valid,
    input  logic [7:0]  s_roce_rx_bth_op_code,
    input  logic [23:0] s_roce_rx_bth_psn,
    input  logic [23:0] s_roce_rx_bth_dest_qp,
    input  logic        s_roce_rx_bth_ack_req,
    output logic        m_roce_ack_valid,
    input  logic        m_roce_ack_ready,
    output logic [7:0]  m_roce_ack_op_code,
    output logic [23:0] m_roce_ack_psn,
    output logic [23:0] m_roce_ack_dest_qp,
    output logic [7:0]  m_roce_ack_syndrome,
    output logic [23:0] m_roce_ack_msn,
    output logic [31:0] stat_nak_count
);

    logic [23:0] epsn_q, epsn_d;
    logic [23:0] msn_q, msn_d;
    logic        in_msg_q, in_msg_d;
    logic        nak_sent_q, nak_sent_d;
    logic [23:0] loc_qp_q, rem_qp_q;
    logic        a_vld_q, a_vld_d;
    ack_hdr_t    a_q, a_d;
    logic        b_vld_q, b_vld_d;
    ack_hdr_t    b_q, b_d;
    logic [31:0] nak_cnt_q;

    logic        op_first, op_mid, op_last, op_only;
    logic        pkt;
    psn_class_t  cls;
    logic        ev_vld, ev_nak, ev_ack_want;
    ack_hdr_t    ev_hdr;
    logic        acc, a_is_nak, nak_in;

    always_comb begin
        op_first = s_roce_rx_bth_op_code == RC_RDMA_WRITE_FIRST;
        op_mid   = s_roce_rx_bth_op_code == RC_RDMA_WRITE_MIDDLE;
        op_last  = (s_roce_rx_bth_op_code == RC_RDMA_WRITE_LAST) ||
                   (s_roce_rx_bth_op_code == RC_RDMA_WRITE_LAST_IMD);
        op_only  = (s_roce_rx_bth_op_code == RC_RDMA_WRITE_ONLY) ||
                   (s_roce_rx_bth_op_code == RC_RDMA_WRITE_ONLY_IMD);
        pkt = s_roce_rx_bth_valid &&
              (s_roce_rx_bth_dest_qp == loc_qp_q) &&
              (op_first || op_mid || op_last || op_only);
        cls = psn_classify(s_roce_rx_bth_psn, epsn_q);
`ifdef ROCE_ACK_COALESCE_EN
        ev_ack_want = s_roce_rx_bth_ack_req || op_last || op_only;
`else
        ev_ack_want = 1'b1;
`endif
    end

    // Packet classification and sequence state update.
    always_comb begin
        epsn_d     = epsn_q;
        msn_d      = msn_q;
        in_msg_d   = in_msg_q;
        nak_sent_d = nak_sent_q;
        ev_vld     = 1'b0;
        ev_nak     = 1'b0;
        ev_hdr     = '0;
        if (pkt) begin
            unique case (cls)
                IN_SEQ: begin
                    if (((op_mid || op_last) && !in_msg_q) ||
                        ((op_first || op_only) && in_msg_q)) begin
                        ev_vld   = 1'b1;
                        ev_nak   = 1'b1;
                        ev_hdr   = '{epsn_q, AETH_NAK_INV_REQ, msn_q};
                        in_msg_d = 1'b0;
                    end else begin
                        epsn_d     = epsn_q + 24'd1;
                        nak_sent_d = 1'b0;
                        if (op_first)
                            in_msg_d = 1'b1;
                        if (op_last || op_only) begin
                            in_msg_d = 1'b0;
                            msn_d    = msn_q + 24'd1;
                        end
                        ev_vld = ev_ack_want;
                        ev_hdr = '{s_roce_rx_bth_psn, AETH_ACK, msn_d};
                    end
                end
                DUP: begin
                    ev_vld = 1'b1;
                    ev_hdr = '{epsn_q - 24'd1, AETH_ACK, msn_q};
                end
                AHEAD: begin
                    if (!nak_sent_q) begin
                        ev_vld     = 1'b1;
                        ev_nak     = 1'b1;
                        ev_hdr     = '{epsn_q, AETH_NAK_PSN_SEQ, msn_q};
                        nak_sent_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot scheduling: B only ever holds an ACK queued behind A.
    always_comb begin
        acc     = a_vld_q && m_roce_ack_ready;
        a_vld_d = a_vld_q && !acc;
        a_d     = a_q;
        b_vld_d = b_vld_q;
        b_d     = b_q;
        nak_in  = 1'b0;
        if (acc && b_vld_q) begin
            a_vld_d = 1'b1;
            a_d     = b_q;
            b_vld_d = 1'b0;
        end
        a_is_nak = a_d.syndrome != AETH_ACK;
        if (ev_vld) begin
            if (!a_vld_d) begin
                a_vld_d = 1'b1;
                a_d     = ev_hdr;
                nak_in  = ev_nak;
            end else if (a_is_nak) begin
                if (!ev_nak) begin
                    b_vld_d = 1'b1;
                    b_d     = ev_hdr;
                end
            end else if (ev_nak) begin
                a_d    = ev_hdr;
                nak_in = 1'b1;
            end else begin
`ifdef ROCE_ACK_COALESCE_EN
                a_d = ev_hdr;
`else
                b_vld_d = 1'b1;
                b_d     = ev_hdr;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epsn_q     <= '0;
            msn_q      <= '0;
            in_msg_q   <= 1'b0;
            nak_sent_q <= 1'b0;
            loc_qp_q   <= '0;
            rem_qp_q   <= '0;
            a_vld_q    <= 1'b0;
            a_q        <= '0;
            b_vld_q    <= 1'b0;
            b_q        <= '0;
            nak_cnt_q  <= '0;
        end else if (cfg_load) begin
            epsn_q     <= cfg_start_psn;
            msn_q      <= '0;
            in_msg_q   <= 1'b0;
            nak_sent_q <= 1'b0;
            loc_qp_q   <= cfg_loc_qp;
            rem_qp_q   <= cfg_rem_qp;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
        end else begin
            epsn_q     <= epsn_d;
            msn_q      <= msn_d;
            in_msg_q   <= in_msg_d;
            nak_sent_q <= nak_sent_d;
            a_vld_q    <= a_vld_d;
            a_q        <= a_d;
            b_vld_q    <= b_vld_d;
            b_q        <= b_d;
            if (nak_in && (nak_cnt_q != 32'hFFFF_FFFF))
                nak_cnt_q <= nak_cnt_q + 32'd1;
        end
    end

    assign m_roce_ack_valid    = a_vld_q;
    assign m_roce_ack_op_code  = RC_RDMA_ACK;
    assign m_roce_ack_psn      = a_q.psn;
    assign m_roce_ack_syndrome = a_q.syndrome;
    assign m_roce_ack_msn      = a_q.msn;
    assign m_roce_ack_dest_qp  = rem_qp_q;
    assign stat_nak_count      = nak_cnt_q;

endmodule

// File: tb/tb_roce_ack_responder.sv
// Directed plus randomized bench for roce_ack_responder against a
// queue-based model of the responder's pending-header list.
module tb_roce_ack_responder;

    localparam int MASK = 32'h00FF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_load = 1'b0;
    logic [23:0] cfg_start_psn = '0;
    logic [23:0] cfg_loc_qp = '0;
    logic [23:0] cfg_rem_qp = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_op = '0;
    logic [23:0] rx_psn = '0;
    logic [23:0] rx_qp = '0;
    logic        rx_ar = 1'b0;
    logic        ack_valid;
    logic        ack_ready = 1'b0;
    logic [7:0]  ack_op;
    logic [23:0] ack_psn;
    logic [23:0] ack_qp;
    logic [7:0]  ack_syn;
    logic [23:0] ack_msn;
    logic [31:0] nak_cnt;

    roce_ack_responder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cfg_load              (cfg_load),
        .cfg_start_psn         (cfg_start_psn),
        .cfg_loc_qp            (cfg_loc_qp),
        .cfg_rem_qp            (cfg_rem_qp),
        .s_roce_rx_bth_valid   (rx_valid),
        .s_roce_rx_bth_op_code (rx_op),
        .s_roce_rx_bth_psn     (rx_psn),
        .s_roce_rx_bth_dest_qp (rx_qp),
        .s_roce_rx_bth_ack_req (rx_ar),
        .m_roce_ack_valid      (ack_valid),
        .m_roce_ack_ready      (ack_ready),
        .m_roce_ack_op_code    (ack_op),
        .m_roce_ack_psn        (ack_psn),
        .m_roce_ack_dest_qp    (ack_qp),
        .m_roce_ack_syndrome   (ack_syn),
        .m_roce_ack_msn        (ack_msn),
        .stat_nak_count        (nak_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int psn;
        int syn;
        int msn;
    } hdr_t;

    int   checks = 0;
    int   failures = 0;
    int   m_epsn, m_msn, m_loc, m_rem;
    int   m_cnt;
    bit   m_in, m_nsent;
    hdr_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_epsn = 0; m_msn = 0; m_loc = 0; m_rem = 0; m_cnt = 0;
        m_in = 0; m_nsent = 0;
        q.delete();
    endtask

    // Enter a new header into the ordered list of pending headers.
    task automatic place(input hdr_t h, input bit nak);
        if (q.size() == 0) begin
            q.push_back(h);
            if (nak) m_cnt++;
        end else if (q[0].syn != 'h1F) begin
            if (!nak) begin
                if (q.size() == 2) q[1] = h;
                else q.push_back(h);
            end
        end else if (nak) begin
            q[0] = h;
            m_cnt++;
        end else begin
`ifdef ROCE_ACK_COALESCE_EN
            q[0] = h;
`else
            if (q.size() == 2) q[1] = h;
            else q.push_back(h);
`endif
        end
    endtask

    task automatic model();
        int d, op;
        bit first, mid, last, only, want;
        hdr_t h;
        if (cfg_load) begin
            m_epsn = int'(cfg_start_psn); m_msn = 0;
            m_in = 0; m_nsent = 0;
            m_loc = int'(cfg_loc_qp); m_rem = int'(cfg_rem_qp);
            q.delete();
            return;
        end
        if (q.size() != 0 && ack_ready) void'(q.pop_front());
        op = int'(rx_op);
        first = op == 6; mid = op == 7;
        last = op == 8 || op == 9; only = op == 10 || op == 11;
        if (!(rx_valid && int'(rx_qp) == m_loc &&
              (first || mid || last || only))) return;
        d = (int'(rx_psn) - m_epsn) & MASK;
        if (d == 0) begin
            if (((mid || last) && !m_in) || ((first || only) && m_in)) begin
                h = '{m_epsn, 'h61, m_msn};
                m_in = 0;
                place(h, 1);
            end else begin
                m_epsn = (m_epsn + 1) & MASK;
                if (first) m_in = 1;
                if (last || only) begin
                    m_in = 0;
                    m_msn = (m_msn + 1) & MASK;
                end
                m_nsent = 0;
`ifdef ROCE_ACK_COALESCE_EN
                want = rx_ar || last || only;
`else
                want = 1;
`endif
                h = '{int'(rx_psn), 'h1F, m_msn};
                if (want) place(h, 0);
            end
        end else if (d >= 'h80_0000) begin
            h = '{(m_epsn - 1) & MASK, 'h1F, m_msn};
            place(h, 0);
        end else if (!m_nsent) begin
            m_nsent = 1;
            h = '{m_epsn, 'h60, m_msn};
            place(h, 1);
        end
    endtask

    task automatic check_out();
        chk("valid", 32'(ack_valid), 32'(q.size() != 0));
        chk("op_code", 32'(ack_op), 32'h11);
        chk("dest_qp", 32'(ack_qp), m_rem);
        chk("nak_count", nak_cnt, m_cnt);
        if (q.size() != 0) begin
            chk("psn", 32'(ack_psn), q[0].psn);
            chk("syndrome", 32'(ack_syn), q[0].syn);
            chk("msn", 32'(ack_msn), q[0].msn);
        end
    endtask

    task automatic step(input bit v, input int op, input int psn,
                        input bit ar, input bit rdy, input int qp);
        rx_valid = v; rx_op = 8'(op); rx_psn = 24'(psn);
        rx_ar = ar; ack_ready = rdy; rx_qp = 24'(qp);
        model();
        @(posedge clk);
        @(negedge clk);
        rx_valid = 0; cfg_load = 0;
        check_out();
    endtask

    task automatic pkt(input int op, input int psn, input bit ar,
                       input bit rdy);
        step(1, op, psn, ar, rdy, m_loc);
    endtask

    task automatic load(input int sp, input int lq, input int rq);
        cfg_load = 1; cfg_start_psn = 24'(sp);
        cfg_loc_qp = 24'(lq); cfg_rem_qp = 24'(rq);
        step(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int op, psn;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_out();
        chk("rst_psn", 32'(ack_psn), 0);
        chk("rst_msn", 32'(ack_msn), 0);

        load('h100, 'h12, 'h34);
        pkt(6, 'h100, 0, 1);
        pkt(7, 'h101, 0, 1);
        pkt(8, 'h102, 1, 1);
        chk("inorder_psn", 32'(ack_psn), 'h102);
        chk("inorder_msn", 32'(ack_msn), 1);
        chk("inorder_syn", 32'(ack_syn), 'h1F);

        pkt(7, 'h105, 0, 1);
        chk("gap_syn", 32'(ack_syn), 'h60);
        chk("gap_psn", 32'(ack_psn), 'h103);
        pkt(7, 'h106, 0, 1);
        chk("gap_drop", 32'(ack_valid), 0);
        chk("gap_cnt", nak_cnt, 1);

        pkt(10, 'h0FF, 0, 1);
        chk("dup_psn", 32'(ack_psn), 'h102);
        chk("dup_msn", 32'(ack_msn), 1);

        load('hFFFFFF, 'h12, 'h34);
        pkt(10, 'hFFFFFF, 0, 1);
        chk("wrap0_psn", 32'(ack_psn), 'hFFFFFF);
        chk("wrap0_msn", 32'(ack_msn), 1);
        pkt(10, 'h000000, 0, 1);
        chk("wrap1_psn", 32'(ack_psn), 0);
        chk("wrap1_msn", 32'(ack_msn), 2);

        pkt(7, 'h5, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, m_loc);
        pkt(10, 'h1, 0, 0);
        chk("bp_nak_syn", 32'(ack_syn), 'h60);
        chk("bp_nak_psn", 32'(ack_psn), 'h1);
        step(0, 0, 0, 0, 1, m_loc);
        chk("bp_ack_syn", 32'(ack_syn), 'h1F);
        chk("bp_ack_psn", 32'(ack_psn), 'h1);
        chk("bp_ack_msn", 32'(ack_msn), 3);
        step(0, 0, 0, 0, 1, m_loc);
        chk("bp_empty", 32'(ack_valid), 0);

        pkt(7, 'h2, 0, 1);
        chk("order_syn", 32'(ack_syn), 'h61);
        chk("order_psn", 32'(ack_psn), 'h2);
        pkt(10, 'h2, 0, 1);
        chk("order_next", 32'(ack_psn), 'h2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    load(MASK - int'($urandom_range(0, 3)), 'h12, 'h34);
                else
                    load(int'($urandom_range(0, MASK)), 'h12, 'h77);
            end else begin
                if ($urandom_range(0, 3) != 0)
                    op = m_in ? 7 + int'($urandom_range(0, 2))
                              : (($urandom_range(0, 1) == 1) ? 6
                                 : 10 + int'($urandom_range(0, 1)));
                else
                    op = 4 + int'($urandom_range(0, 7));
                psn = (m_epsn + int'($urandom_range(0, 9)) - 3) & MASK;
                if ($urandom_range(0, 2) != 0) psn = m_epsn;
                step($urandom_range(0, 4) != 0, op, psn,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 7,
                     ($urandom_range(0, 9) == 0) ? 'h13 : m_loc);
            end
        end

        pkt(7, (m_epsn + 4) & MASK, 0, 0);
        pkt(7, m_epsn, 0, 0);
        chk("pre_rst_valid", 32'(ack_valid), 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst_valid", 32'(ack_valid), 0);
        chk("midrst_cnt", nak_cnt, 0);
        chk("midrst_psn", 32'(ack_psn), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roce_ack_responder.md
# roce_ack_responder

Responder-side RC acknowledgement generator for RDMA WRITE traffic. Monitors received BTH headers on the RX path, tracks the expected PSN and MSN per the single configured QP, and emits ACK/NAK headers (BTH+AETH) toward the TX header path. It is the counterpart of the initiator-side latency/ACK monitor: the PSNs it acknowledges are the ones that monitor matches.

## Interface
- No parameters. Opcodes, syndromes and PSN helpers come from `RoCE_params`.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cfg_load` in 1: pulse; loads the `cfg_*` values and clears the state.
- `cfg_start_psn` in 24: initial expected PSN.
- `cfg_loc_qp` in 24: local QP. Only packets addressed to this QP are processed.
- `cfg_rem_qp` in 24: remote QP, placed in `dest_qp` of the generated ACKs.
- `s_roce_rx_bth_valid` in 1: RX BTH strobe. One cycle per packet, with no backpressure.
- `s_roce_rx_bth_op_code` in 8: RX opcode.
- `s_roce_rx_bth_psn` in 24: RX PSN.
- `s_roce_rx_bth_dest_qp` in 24: RX destination QP.
- `s_roce_rx_bth_ack_req` in 1: RX AckReq bit.
- `m_roce_ack_valid` in/out: out 1. ACK header valid.
- `m_roce_ack_ready` in 1: downstream ready.
- `m_roce_ack_op_code` out 8: always `RC_RDMA_ACK`.
- `m_roce_ack_psn` out 24: acknowledged PSN.
- `m_roce_ack_dest_qp` out 24: equals `cfg_rem_qp`.
- `m_roce_ack_syndrome` out 8: AETH syndrome.
- `m_roce_ack_msn` out 24: AETH MSN.
- `stat_nak_count` out 32: number of NAKs issued. Saturating.

## Operation
- **State:**
  - `epsn` (24 b): expected PSN.
  - `msn` (24 b).
  - `in_msg`: a FIRST has been seen without its LAST.
  - `nak_sent`.
  - Slot A: primary pending header.
  - Slot B: deferred ACK.
- **Processed packet:** `bth_valid`, `dest_qp == cfg_loc_qp`, and opcode in WRITE {FIRST, MIDDLE, LAST, LAST_IMD, ONLY, ONLY_IMD}. All other packets are ignored.
- **Classification** uses `d = (psn - epsn) mod 2^24`:
  - `d == 0`: in-sequence.
  - `d >= 2^23`: duplicate.
  - Otherwise: ahead.
- **In-sequence, opcode-order violation** (MIDDLE/LAST with `!in_msg`, or FIRST/ONLY with `in_msg`):
  - NAK with syndrome `AETH_NAK_INV_REQ` (0x61) and `psn = epsn`.
  - `epsn` is not advanced and `in_msg` is cleared.
- **In-sequence, valid order:**
  - `epsn += 1`, mod 2^24.
  - `in_msg` is set by FIRST and cleared by LAST*/ONLY*.
  - LAST*/ONLY* increments `msn` (mod 2^24).
  - `nak_sent` is cleared.
  - An ACK (syndrome `AETH_ACK` 0x1F, `psn` = packet PSN, `msn` = updated value) is scheduled when `ack_req`, LAST* or ONLY* is true. See Configuration.
- **Duplicate:** ACK scheduled with `psn = epsn - 1` and the current `msn`. No state change.
- **Ahead:**
  - If `!nak_sent`: NAK `AETH_NAK_PSN_SEQ` (0x60) with `psn = epsn`, and `nak_sent` is set.
  - Otherwise the packet is silently dropped.
- **Scheduling into the slots:**
  - If slot A is empty, or holds an ACK that is not being accepted this cycle, the new header overwrites A. This coalesces ACKs, and a NAK replaces an ACK.
  - A pending NAK in A is never overwritten. A new ACK goes to slot B (overwriting B). A new NAK while A holds a NAK is dropped.
  - If A is accepted (`valid & ready`) in the same cycle as a new event, the new header loads A.
  - When A is accepted with B full, B moves to A and B is cleared.
- **`stat_nak_count`:** increments when a NAK enters slot A and saturates at 0xFFFF_FFFF.
- **`cfg_load`:**
  - Sets `epsn = cfg_start_psn`, `msn = 0`, clears `in_msg`, `nak_sent` and both slots, and latches the QPs.
  - It has priority over a packet in the same cycle; that packet is discarded.
  - `stat_nak_count` is not cleared by `cfg_load`.

## Timing
- **Reset values:** every output and all state are 0, except `m_roce_ack_op_code = RC_RDMA_ACK`.
- **Latency:** a header is visible on `m_roce_ack_*` exactly 1 cycle after the triggering `bth_valid`, provided slot A was free.
- **Handshake:** outputs are held stable while `valid & !ready`, unless overwritten by coalescing. Coalescing is only allowed when A holds an ACK.
- **Throughput:** one RX packet per cycle is classified at full rate. ACK output rate is 1 per cycle.
- **Wrap-around:** `epsn` 0xFFFFFF advances to 0x000000. The duplicate/ahead window follows the mod-2^24 rule above.
- **Reset:** `rst_n` asserted mid-operation discards pending headers immediately.

## Configuration
- `ROCE_ACK_COALESCE_EN` defined: in-sequence packets are ACKed only on `ack_req`, LAST* or ONLY*. Slot A ACK overwrite is enabled.
- `ROCE_ACK_COALESCE_EN` undefined:
  - Every in-sequence packet schedules an ACK.
  - An ACK in slot A is never overwritten. A new ACK while A is full goes to B; if B is full it overwrites B.
  - NAK rules are unchanged.

## Structure
- `RoCE_params` gains:
  - `RC_RDMA_ACK`.
  - `AETH_ACK`, `AETH_NAK_PSN_SEQ`, `AETH_NAK_INV_REQ`.
  - A `psn_class_t` enum (IN_SEQ, DUP, AHEAD) and a `psn_classify(psn, epsn)` function.
  - An `ack_hdr_t` struct {psn, syndrome, msn}.
- No sub-module. Slots A and B are two `ack_hdr_t` registers with valid bits inside this module.

## Test plan
- **Start PSN 0x000100, in-order packets:** `cfg_start_psn=0x000100`; FIRST 0x100, MIDDLE 0x101, LAST 0x102 (ack_req=1), ready=1. Response: a single ACK psn=0x102, msn=1, syndrome=0x1F; `epsn=0x103`.
- **PSN gap:** after the above, MIDDLE psn=0x105 then 0x106. Response: one NAK 0x60 with psn=0x103, the second packet dropped, `stat_nak_count=1`.
- **Duplicate:** ONLY psn=0x0FF. Response: ACK psn=0x102, msn=1, no state change.
- **PSN wrap:** `cfg_start_psn=0xFFFFFF`; ONLY 0xFFFFFF, ONLY 0x000000. Response: ACKs psn=0xFFFFFF (msn=1) and psn=0x000000 (msn=2).
- **Backpressure:** ready=0 for 10 cycles while a NAK is pending, then a valid ONLY arrives, then ready=1. Response: the NAK is emitted first, then the ACK from slot B, with no loss.
- **Opcode order:** MIDDLE with `in_msg=0`. Response: NAK 0x61 with psn=`epsn`; `epsn` unchanged.
